// File: rtl/dii_pkt_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dii_pkt_fifo_pkg
// Description : Shared DII flit type and sizing helper for the packet FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package dii_pkt_fifo_pkg;

  // Data width carried by every DII flit.
  localparam int DII_WIDTH = 16;

  // One DII flit: payload, end-of-packet marker and valid qualifier.
  typedef struct packed {
    logic [DII_WIDTH-1:0] data;
    logic                 last;
    logic                 valid;
  } dii_flit;

  // Bits needed to hold the values 0..n inclusive (counts that may reach n).
  function automatic int dii_clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dii_pkt_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : dii_pkt_fifo_if
// Description : DII flit link: flit travels master->slave, ready slave->master.
// Revision    : 1.0 - initial release
// ============================================================================
interface dii_pkt_fifo_if;

  dii_pkt_fifo_pkg::dii_flit flit;
  logic                      ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);

endinterface
`default_nettype wire

// File: rtl/dii_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dii_pkt_fifo
// Description : Circular DII flit FIFO with fill/packet/head-size status and
//               optional store-and-forward with an escape for packets longer
//               than DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module dii_pkt_fifo
  import dii_pkt_fifo_pkg::*;
#(
  parameter int WIDTH      = 16,  // must equal DII_WIDTH
  parameter int DEPTH      = 8,   // power of two, >= 2
  parameter int FULLPACKET = 0    // 1: offer head only once a full packet is stored
) (
  input  logic                            clk,
  input  logic                            rst,       // asynchronous, active-low
  dii_pkt_fifo_if.slave                   flit_in,
  dii_pkt_fifo_if.master                  flit_out,
  output logic [dii_clog2p1(DEPTH)-1:0]   fill_level,
  output logic [dii_clog2p1(DEPTH)-1:0]   packet_count,
  output logic [dii_clog2p1(DEPTH)-1:0]   head_packet_size,
  output logic                            empty,
  output logic                            full,
  output logic                            cut_through
);

  localparam int CW = dii_clog2p1(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0] r_mem_last;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_pkt_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic [CW-1:0]    w_head_size;

  // Status is derived purely from registered state.
  assign fill_level   = r_count;
  assign packet_count = r_pkt_cnt;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign cut_through  = (FULLPACKET != 0) && full && (r_pkt_cnt == '0);

  // Ready ignores pop on purpose: a full FIFO never accepts in the same cycle.
  assign flit_in.ready = !full;

  // Store-and-forward holds the head back until a packet end is stored, or
  // the FIFO is full (escape), so oversized packets still drain.
  assign w_out_valid = (FULLPACKET != 0) ? (!empty && ((r_pkt_cnt != '0) || full))
                                         : !empty;

  assign flit_out.flit = '{data:  r_mem_data[r_rd_ptr],
                           last:  r_mem_last[r_rd_ptr],
                           valid: w_out_valid};

  assign w_push = flit_in.flit.valid & flit_in.ready;
  assign w_pop  = w_out_valid & flit_out.ready;

  // Storage array: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= flit_in.flit.data;
      r_mem_last[r_wr_ptr] <= flit_in.flit.last;
    end
  end

  // Pointers, fill count and stored-packet count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pkt_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      if ((w_push && flit_in.flit.last) && !(w_pop && r_mem_last[r_rd_ptr]))
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      else if (!(w_push && flit_in.flit.last) && (w_pop && r_mem_last[r_rd_ptr]))
        r_pkt_cnt <= r_pkt_cnt - 1'b1;
    end
  end

  // Head packet size: distance to the first stored last flit, else fill level.
  always_comb begin
    logic          w_found;
    logic [PW-1:0] w_idx;
    w_head_size = r_count;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if (!w_found && (CW'(i) < r_count) && r_mem_last[w_idx]) begin
        w_found     = 1'b1;
        w_head_size = CW'(i + 1);
      end
    end
  end

  assign head_packet_size = w_head_size;

endmodule
`default_nettype wire

// File: tb/tb_dii_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_dii_pkt_fifo
// Description : Scoreboard bench for dii_pkt_fifo, one cut-through instance
//               (sel 0) and one store-and-forward instance (sel 1), DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dii_pkt_fifo;
  import dii_pkt_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dii_pkt_fifo_if in0 ();
  dii_pkt_fifo_if out0 ();
  dii_pkt_fifo_if in1 ();
  dii_pkt_fifo_if out1 ();

  logic [CW-1:0] fill0, pkt0, head0, fill1, pkt1, head1;
  logic          empty0, full0, ct0, empty1, full1, ct1;

  dii_pkt_fifo #(.WIDTH(16), .DEPTH(DEPTH), .FULLPACKET(0)) u_dut0 (
    .clk(clk), .rst(rst), .flit_in(in0), .flit_out(out0),
    .fill_level(fill0), .packet_count(pkt0), .head_packet_size(head0),
    .empty(empty0), .full(full0), .cut_through(ct0)
  );

  dii_pkt_fifo #(.WIDTH(16), .DEPTH(DEPTH), .FULLPACKET(1)) u_dut1 (
    .clk(clk), .rst(rst), .flit_in(in1), .flit_out(out1),
    .fill_level(fill1), .packet_count(pkt1), .head_packet_size(head1),
    .empty(empty1), .full(full1), .cut_through(ct1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];

  // Output monitors: every handshake on flit_out is compared with the queue.
  always @(negedge clk) begin
    logic [16:0] e0;
    if (rst && out0.flit.valid && out0.ready) begin
      n_checks++;
      if (q0.size() == 0) begin
        n_errors++;
        $display("FAIL out0_unexpected: got data=%h last=%b, required no flit",
                 out0.flit.data, out0.flit.last);
      end else begin
        e0 = q0.pop_front();
        if ({out0.flit.data, out0.flit.last} !== e0) begin
          n_errors++;
          $display("FAIL out0_flit: got data=%h last=%b, required data=%h last=%b",
                   out0.flit.data, out0.flit.last, e0[16:1], e0[0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] e1;
    if (rst && out1.flit.valid && out1.ready) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_errors++;
        $display("FAIL out1_unexpected: got data=%h last=%b, required no flit",
                 out1.flit.data, out1.flit.last);
      end else begin
        e1 = q1.pop_front();
        if ({out1.flit.data, out1.flit.last} !== e1) begin
          n_errors++;
          $display("FAIL out1_flit: got data=%h last=%b, required data=%h last=%b",
                   out1.flit.data, out1.flit.last, e1[16:1], e1[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] d, input logic l);
    if (sel == 0) in0.flit = '{data: d, last: l, valid: v};
    else          in1.flit = '{data: d, last: l, valid: v};
  endtask

  task automatic set_ready(input int sel, input logic r);
    if (sel == 0) out0.ready = r;
    else          out1.ready = r;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Offer one flit until accepted (bounded); entered and left at posedge+1.
  task automatic push(input int sel, input logic [15:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    drive(sel, 1'b1, d, l);
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      ok = (sel == 0) ? in0.ready : in1.ready;
      sync();
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL push_timeout: sel=%0d data=%h got not accepted, required accepted", sel, d);
    end else if (sel == 0) q0.push_back({d, l});
    else                   q1.push_back({d, l});
    drive(sel, 1'b0, 16'h0000, 1'b0);
  endtask

  // Wait (bounded) until every expected flit has been seen at the output.
  task automatic drain(input int sel);
    int left;
    for (int n = 0; n < 60; n++) begin
      left = (sel == 0) ? q0.size() : q1.size();
      if (left == 0) break;
      sync();
    end
    left = (sel == 0) ? q0.size() : q1.size();
    chk("drain_outstanding", left, 0);
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pkt;
    rst = 1'b1;
    drive(0, 1'b1, 16'hBEEF, 1'b1);
    drive(1, 1'b0, 16'h0000, 1'b0);
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    #1 rst = 1'b0;

    // Reset held with a valid flit waiting upstream.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_in_ready0", int'(in0.ready), 1);
      chk("rst_out_valid0", int'(out0.flit.valid), 0);
      chk("rst_fill0", int'(fill0), 0);
      chk("rst_empty0", int'(empty0), 1);
    end
    chk("rst_full1", int'(full1), 0);
    chk("rst_cut_through1", int'(ct1), 0);
    chk("rst_head1", int'(head1), 0);
    chk("rst_pkt1", int'(pkt1), 0);
    sync();
    rst = 1'b1;
    push(0, 16'hBEEF, 1'b1);
    chk("first_fill0", int'(fill0), 1);
    chk("first_pkt0", int'(pkt0), 1);
    chk("first_head0", int'(head0), 1);
    set_ready(0, 1'b1);
    drain(0);
    chk("first_empty0", int'(empty0), 1);

    // Cut-through fill against a stalled sink, then drain.
    set_ready(0, 1'b0);
    push(0, 16'h00A0, 1'b0);
    chk("ct_head_nolast", int'(head0), 1);
    chk("ct_pkt_nolast", int'(pkt0), 0);
    push(0, 16'h00A1, 1'b0);
    push(0, 16'h00A2, 1'b0);
    push(0, 16'h00A3, 1'b1);
    chk("ct_full", int'(full0), 1);
    chk("ct_in_ready_full", int'(in0.ready), 0);
    chk("ct_fill", int'(fill0), 4);
    chk("ct_pkt", int'(pkt0), 1);
    chk("ct_head", int'(head0), 4);
    chk("ct_head_data", int'(out0.flit.data), 'hA0);
    set_ready(0, 1'b1);
    drain(0);
    chk("ct_empty", int'(empty0), 1);

    // Store-and-forward: head held until the packet end is stored.
    set_ready(1, 1'b1);
    push(1, 16'h0011, 1'b0);
    chk("sf_valid_partial", int'(out1.flit.valid), 0);
    chk("sf_head_partial", int'(head1), 1);
    sync();
    chk("sf_valid_partial2", int'(out1.flit.valid), 0);
    push(1, 16'h0022, 1'b1);
    chk("sf_valid_complete", int'(out1.flit.valid), 1);
    chk("sf_head", int'(head1), 2);
    chk("sf_pkt", int'(pkt1), 1);
    drain(1);
    chk("sf_pkt_after", int'(pkt1), 0);
    chk("sf_empty_after", int'(empty1), 1);

    // Escape: a 5-flit packet in a 4-deep store-and-forward FIFO.
    push(1, 16'h0001, 1'b0);
    push(1, 16'h0002, 1'b0);
    push(1, 16'h0003, 1'b0);
    chk("esc_valid_partial", int'(out1.flit.valid), 0);
    push(1, 16'h0004, 1'b0);
    chk("esc_cut_through", int'(ct1), 1);
    chk("esc_full", int'(full1), 1);
    chk("esc_valid", int'(out1.flit.valid), 1);
    push(1, 16'h0005, 1'b1);
    drain(1);
    chk("esc_pkt_after", int'(pkt1), 0);
    chk("esc_ct_after", int'(ct1), 0);
    chk("esc_empty_after", int'(empty1), 1);

    // Steady push and pop at fill level 2 across several pointer wraps.
    set_ready(0, 1'b0);
    push(0, 16'h00B0, 1'b0);
    push(0, 16'h00B1, 1'b0);
    chk("wrap_prefill", int'(fill0), 2);
    set_ready(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      push(0, 16'h0100 + 16'(i), (i % 4) == 3);
      exp_pkt = (((i % 4) == 3) ? 1 : 0) + (((i >= 1) && (((i - 1) % 4) == 3)) ? 1 : 0);
      chk("wrap_fill", int'(fill0), 2);
      chk("wrap_pkt", int'(pkt0), exp_pkt);
    end
    drain(0);
    chk("wrap_empty", int'(empty0), 1);

    // Asynchronous reset between edges with three flits stored.
    set_ready(0, 1'b0);
    push(0, 16'h00D0, 1'b0);
    push(0, 16'h00D1, 1'b0);
    push(0, 16'h00D2, 1'b0);
    chk("arst_fill_before", int'(fill0), 3);
    #3 rst = 1'b0;
    #1;
    chk("arst_fill", int'(fill0), 0);
    chk("arst_empty", int'(empty0), 1);
    chk("arst_valid", int'(out0.flit.valid), 0);
    chk("arst_in_ready", int'(in0.ready), 1);
    chk("arst_pkt", int'(pkt0), 0);
    chk("arst_head", int'(head0), 0);
    q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    sync();
    set_ready(0, 1'b1);
    repeat (3) sync();
    chk("arst_empty_after", int'(empty0), 1);
    push(0, 16'h00E0, 1'b1);
    drain(0);
    chk("arst_final_empty", int'(empty0), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
